// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streaming byte loader that fills instruction memory and releases core reset
// Optional trailing XOR checksum byte enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_loader #(
    parameter int WORDS  = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    localparam int          CNT_W   = $clog2(WORDS + 1);
    localparam logic [31:0] WORDS_U = WORDS;

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             ready_next;
    logic             accept;
    logic             len_bad;
    logic             last_word;
    logic             word_full;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      word_buf;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    assign accept    = in_valid & in_ready;
    assign len_bad   = (in_data == 8'd0) || ({24'd0, in_data} > WORDS_U);
    assign last_word = (word_idx == word_cnt - CNT_W'(1));
    assign word_full = (state == S_DATA) && accept && (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LEN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready_next = 1'b0;
        case (state)
            S_LEN: begin
                if (accept) begin
                    next_state = len_bad ? S_ERR : S_DATA;
                end
            end
            S_DATA: begin
                if (word_full) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!last_word) begin
                    next_state = S_DATA;
                end else begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    next_state = S_CHK;
`else
                    next_state = S_RUN;
`endif
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    next_state = (in_data == csum) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN:   next_state = S_RUN;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ERR;
        endcase
        // in_ready is registered off the next state so it is low throughout reset
        case (next_state)
            S_LEN, S_DATA: ready_next = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK:         ready_next = 1'b1;
`endif
            default:       ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
        end else begin
            in_ready <= ready_next;
            imem_we  <= word_full;
            cpu_rst  <= (next_state == S_RUN);
            done     <= (next_state == S_RUN);
            err      <= (next_state == S_ERR);
            if (state == S_LEN && accept && !len_bad) begin
                word_cnt <= in_data[CNT_W-1:0];
            end
            if (state == S_DATA && accept) begin
                word_buf <= {in_data, word_buf[23:8]};
                byte_idx <= byte_idx + 2'd1;
            end
            // the 4th byte bypasses the buffer straight into the write data
            if (word_full) begin
                imem_waddr <= ADDR_W'({word_idx, 2'b00});
                imem_wdata <= {in_data, word_buf};
            end
            if (state == S_WRITE) begin
                word_idx <= word_idx + CNT_W'(1);
            end
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= 8'd0;
        end else if (accept && (state == S_LEN || state == S_DATA)) begin
            csum <= csum ^ in_data;
        end
    end
`endif

endmodule

// File: doc/boot_loader.md
# boot_loader

Streaming program loader sitting directly upstream of the core's instruction memory and reset input. After reset it accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory through a dedicated write port. It holds the core in reset until the image is fully and correctly loaded, then releases it.

## Interface
- WORDS, 32, instruction memory capacity in 32-bit words (legal image length 1..WORDS)
- ADDR_W, 7, instruction memory byte-address width (matches the core's 7-bit instruction fetch address)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset; one clock domain
- in_valid  input  1  byte on in_data is valid
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at rising edge
- imem_we  output  1  instruction memory write strobe, one-cycle pulse per word
- imem_waddr  output  ADDR_W  byte address of word written, always word-aligned (bits [1:0]=0)
- imem_wdata  output  32  word written
- cpu_rst  output  1  active-low reset to core; 0 while loading, 1 only after successful load
- done  output  1  image loaded, core running
- err  output  1  image rejected, core held in reset

## Operation
- States: LEN, DATA, WRITE, CHK, RUN, ERR. Reset enters LEN.
- Reset values: in_ready=0 during reset, 1 first cycle after release; imem_we=0; imem_waddr=0; imem_wdata=0; cpu_rst=0; done=0; err=0; internal byte index=0, word index=0, checksum=0.
- LEN: in_ready=1. First accepted byte is word count N. N=0 or N>WORDS -> ERR. Otherwise store N -> DATA.
- DATA: in_ready=1. Bytes shifted into word buffer little-endian (byte 0 -> bits [7:0]). On 4th byte of a word -> WRITE.
- WRITE: in_ready=0; imem_we=1 one cycle, imem_waddr=word_index*4, imem_wdata=assembled word. Word index increments. If word index reaches N -> CHK (or RUN when checksum compiled out); else -> DATA.
- CHK: see Configuration.
- RUN: cpu_rst=1, done=1, in_ready=0. Absorbing; only rst exits.
- ERR: err=1, cpu_rst=0, in_ready=0. Absorbing; only rst exits.
- Bytes offered while in_ready=0 are not consumed; in_valid may drop and return at any time without losing state.
- Address arithmetic: word_index*4 truncated to ADDR_W; WORDS limits never overflow it.
- Reset mid-load: all state returns to reset values immediately, partial word discarded; words already written remain in instruction memory (not cleared). Core stays in reset.

## Timing
- Byte accepted on the rising edge where in_valid=1 and in_ready=1; at most one byte per cycle.
- 4th byte of a word accepted in cycle t -> imem_we=1 in cycle t+1; next byte can be accepted no earlier than t+2.
- Minimum load time with continuous in_valid: 1 + 5N cycles (+1 with checksum) from first ready cycle to RUN.
- cpu_rst and done rise together on the first cycle in RUN, registered (glitch-free). err registered on the first cycle in ERR.
- imem_waddr/imem_wdata are registered and stable during the imem_we cycle.

## Configuration
- BOOT_LOADER_CHECKSUM_EN defined: running XOR of all bytes (length byte included) kept; after last WRITE enter CHK, in_ready=1, accept one byte; equal to running XOR -> RUN, else -> ERR.
- Not defined: no CHK state, no checksum register; last WRITE goes directly to RUN; stream is exactly 1+4N bytes.

## Test plan
- N=2, bytes 13 00 00 00 / 93 00 10 00 continuous -> writes 0x00000013 at addr 0x00, 0x00100093 at addr 0x04, imem_we one cycle each, then cpu_rst=1, done=1, err=0.
- Length byte 0x00 -> err=1, cpu_rst=0, imem_we never asserted, in_ready=0 afterwards.
- Length byte 0x21 (WORDS=32) -> err=1, no writes; N=0x20 with 128 bytes -> last write addr 0x7C, done=1.
- in_valid toggled randomly with 1-3 idle cycles between bytes for N=3 -> identical writes to the continuous case, no byte lost or duplicated, no acceptance during WRITE.
- rst asserted after 6 bytes of N=2 -> outputs at reset values immediately; full N=1 reload afterwards writes only addr 0x00 and reaches RUN.
- With BOOT_LOADER_CHECKSUM_EN, N=1, data 01 02 03 04, checksum 0x05 -> RUN; checksum 0x06 -> err=1, cpu_rst=0.
